// File: rtl/rast_tri_sched.sv
// rast_tri_sched: round-robin triangle arbiter feeding the rast R10 input, with drain-before-config.
module rast_tri_sched #(
  parameter int SIGFIG = 24,
  parameter int VERTS = 3,
  parameter int AXIS = 3,
  parameter int COLORS = 3,
  parameter int REQS = 2,
  parameter int DRAIN_CYC = 8,
  parameter logic [3:0] RST_SUBSAMPLE = 4'b1000
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [REQS-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri_S,
  input  logic [REQS-1:0][COLORS-1:0][SIGFIG-1:0] req_color_U,
  input  logic [REQS-1:0] req_valid_H,
  output logic [REQS-1:0] req_ready_H,
  input  logic signed [1:0][SIGFIG-1:0] cfg_screen_S,
  input  logic [3:0] cfg_subSample_U,
  input  logic cfg_valid_H,
  output logic cfg_ready_H,
  input  logic halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0] color_R10U,
  output logic validTri_R10H,
  output logic signed [1:0][SIGFIG-1:0] screen_RnnnnS,
  output logic [3:0] subSample_RnnnnU,
  output logic busy_H,
  output logic [31:0] tri_count_U
);
  localparam int PW = $clog2(REQS);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;
  state_t state, nstate;
  logic [PW-1:0] ptr, gidx, j;
  logic [DW-1:0] dcnt;
  logic found, accept, free, xfer;
  assign accept = validTri_R10H & halt_RnnnnL;
  assign free = ~validTri_R10H | halt_RnnnnL;
  always_comb begin
    gidx = '0;
    j = '0;
    found = 1'b0;
    for (int k = 0; k < REQS; k++) begin
      j = PW'((int'(ptr) + k) % REQS);
      if (!found && req_valid_H[j]) begin
        found = 1'b1;
        gidx = j;
      end
    end
  end
  assign xfer = found & free & (state == RUN) & ~cfg_valid_H;
  assign req_ready_H = xfer ? REQS'(1) << gidx : '0;
  assign cfg_ready_H = state == APPLY;
  assign busy_H = validTri_R10H | (state != RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= nstate;
  always_comb begin
    nstate = state;
    nstate = state == RUN ? (cfg_valid_H ? DRAIN : RUN) :
             state == DRAIN ? ((halt_RnnnnL && !validTri_R10H && dcnt == DW'(1)) ? APPLY : DRAIN) : RUN;
  end
  // dcnt counts down consecutive empty halt-high cycles; any stall or occupancy restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validTri_R10H <= 1'b0;
      tri_R10S <= '0;
      color_R10U <= '0;
      ptr <= '0;
      dcnt <= DW'(DRAIN_CYC);
      screen_RnnnnS <= '0;
      subSample_RnnnnU <= RST_SUBSAMPLE;
      tri_count_U <= '0;
    end else begin
      if (xfer) begin
        tri_R10S <= req_tri_S[gidx];
        color_R10U <= req_color_U[gidx];
        validTri_R10H <= 1'b1;
        ptr <= (int'(gidx) == REQS - 1) ? '0 : gidx + PW'(1);
      end else if (accept) validTri_R10H <= 1'b0;
      if (accept) tri_count_U <= tri_count_U + 32'd1;
      dcnt <= (state != DRAIN || !halt_RnnnnL || validTri_R10H || dcnt == DW'(1)) ? DW'(DRAIN_CYC) : dcnt - DW'(1);
      if (state == APPLY) begin
        screen_RnnnnS <= cfg_screen_S;
        subSample_RnnnnU <= cfg_subSample_U;
      end
    end
  end
endmodule

// File: doc/rast_tri_sched.md
# rast_tri_sched

Triangle scheduler sitting directly in front of `rast`. It arbitrates round-robin between `REQS` triangle sources and registers the winning triangle onto the rast R10 input. It obeys the rasterizer's `halt_RnnnnL` back-pressure, and it changes the screen and subsample configuration only after the rast pipeline has fully drained.

## Interface
- `SIGFIG`, 24, bits per coordinate/color
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex
- `COLORS`, 3, color channels
- `REQS`, 2, number of triangle requesters (2..8)
- `DRAIN_CYC`, 8, consecutive `halt_RnnnnL`=1 cycles that prove the pipeline is empty (≥ PIPES_HASH+PIPES_SAMP+2)
- `RST_SUBSAMPLE`, 4'b1000, reset value of `subSample_RnnnnU`

Ports:
- `clk`  in  1  clock, single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `req_tri_S`  in  REQS×VERTS×AXIS×SIGFIG  signed triangle per requester
- `req_color_U`  in  REQS×COLORS×SIGFIG  color per requester
- `req_valid_H`  in  REQS  requester has a triangle
- `req_ready_H`  out  REQS  one-hot grant; a transfer occurs when valid&ready
- `cfg_screen_S`  in  2×SIGFIG  new screen dimensions
- `cfg_subSample_U`  in  4  new subsample interval
- `cfg_valid_H`  in  1  config change request; held until `cfg_ready_H`
- `cfg_ready_H`  out  1  one-cycle pulse: config applied
- `halt_RnnnnL`  in  1  from rast; 1 = rast accepts a triangle this cycle
- `tri_R10S`, `color_R10U`, `validTri_R10H`  out  to rast inputs
- `screen_RnnnnS`, `subSample_RnnnnU`  out  to rast config
- `busy_H`  out  1  output slot full, or state ≠ RUN
- `tri_count_U`  out  32  triangles accepted by rast, wraps at 2^32

## Operation
- One-entry output register (slot). Rast accepts when `validTri_R10H & halt_RnnnnL`.
- Slot is free when it is empty, or when it is being accepted this cycle. A new triangle may therefore load in the same cycle the old one leaves.
- **RUN state**
  - If the slot is free and `cfg_valid_H`=0, grant the first requester with `req_valid_H`=1, searching from pointer `ptr` upward modulo `REQS`.
  - `req_ready_H` is combinational from the current valid vector, `ptr`, slot and state.
  - On transfer, `ptr` ← grant+1 (mod REQS). With no transfer, `ptr` holds.
  - A non-granted requester's ready is 0. Requesters must hold valid and data until granted.
- **Config.** When `cfg_valid_H`=1 in RUN, grants stop the same cycle and the state goes to DRAIN.
- **DRAIN state**
  - Wait until the slot is empty.
  - Counter `dcnt` loads `DRAIN_CYC` on entry and whenever `halt_RnnnnL`=0 or the slot is non-empty.
  - Otherwise `dcnt` decrements. At `dcnt`=1 with halt=1, go to APPLY.
- **APPLY state** (one cycle)
  - `screen_RnnnnS`/`subSample_RnnnnU` ← `cfg_*` at the end of the cycle.
  - `cfg_ready_H`=1 in this cycle.
  - Next state is RUN.
- A config request arriving while the slot holds a stalled triangle is serviced only after that triangle is accepted.
- `tri_count_U` increments on every rast acceptance.
- Reset (asynchronous, any time, including mid-DRAIN): state=RUN, slot empty, `validTri_R10H`=0, `tri_R10S`/`color_R10U`=0, `ptr`=0, `dcnt`=`DRAIN_CYC`, `screen_RnnnnS`=0, `subSample_RnnnnU`=`RST_SUBSAMPLE`, `cfg_ready_H`=0, `tri_count_U`=0, `busy_H`=0.

## Timing
- Requester transfer in cycle N gives `validTri_R10H`=1 with that data from cycle N+1.
- Throughput is 1 triangle/cycle while `halt_RnnnnL`=1.
- While `halt_RnnnnL`=0 the slot holds its data and `validTri_R10H` stable. No grants are issued if the slot is full.
- Config latency is at minimum:
  - slot-empty cycle, then
  - `DRAIN_CYC` halt-high cycles, then
  - 1 APPLY cycle.
  - `cfg_ready_H` pulses in the last of these cycles, and the new config is visible the following cycle.
- Registered outputs: `tri_R10S`, `color_R10U`, `validTri_R10H`, `screen_RnnnnS`, `subSample_RnnnnU`, `tri_count_U`.
- Combinational outputs: `req_ready_H`, `cfg_ready_H` (state-decoded), `busy_H`.

## Test plan
- **Fairness.** REQS=2, both valid continuously, halt=1 for 8 cycles → grants alternate 0,1,0,1…; `tri_count_U`=7 after the 8th cycle (the first triangle is accepted one cycle after its grant).
- **Back-pressure.** Requester 0 sends triangle A, halt=0 for 5 cycles → `tri_R10S`=A with `validTri_R10H`=1 held for 5 cycles, `req_ready_H`=0. Halt=1 → A is accepted, B loads the same cycle, count +1.
- **Config drain.** `cfg_valid_H` with screen=(1024,768) and subsample=4'b0100, while a triangle is stalled and halt toggles 0 at drain cycle 3.
  - Required: no grants are issued.
  - `dcnt` reloads when halt drops.
  - `cfg_ready_H` pulses exactly after 8 consecutive halt-high empty cycles.
  - Outputs update the next cycle.
- **Simultaneous events.** `cfg_valid_H` and `req_valid_H` rise in the same cycle → `req_ready_H`=0, config is serviced first, the grant follows in the first RUN cycle.
- **Reset mid-DRAIN.** `rst` is pulsed asynchronously (between clock edges) while in DRAIN with a valid slot.
  - All outputs take their reset values immediately, before the next clock edge.
  - Screen returns to 0 and subsample to 4'b1000.
  - After release, requester 0 is granted first.
